// File: rtl/video_pkg.sv
// Shared definitions for the seven-segment overlay: glyph geometry,
// segment codes and the combinational glyph lookup.
package video_pkg;

    // Glyph is GLYPH_W x GLYPH_H units inside a CELL_W unit wide cell.
    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 5;
    localparam int CELL_W  = 8;

    // Segment word {a,b,c,d,e,f,g}, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // BCD digit to segment word; non-decimal codes render dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One glyph unit lit/unlit for a segment word at (col,row), col/row in 0..4.
    // Horizontal segments span the full row, vertical ones sit on col 0 / col 4.
    function automatic logic glyph_bit(input logic [6:0] seg,
                                       input logic [2:0] col,
                                       input logic [2:0] row);
        logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
        logic left, right, lit;
        seg_a = seg[6];
        seg_b = seg[5];
        seg_c = seg[4];
        seg_d = seg[3];
        seg_e = seg[2];
        seg_f = seg[1];
        seg_g = seg[0];
        left  = (col == 3'd0);
        right = (col == 3'd4);
        case (row)
            3'd0:    lit = seg_a | (seg_f & left) | (seg_b & right);
            3'd1:    lit = (seg_f & left) | (seg_b & right);
            3'd2:    lit = seg_g | ((seg_f | seg_e) & left) | ((seg_b | seg_c) & right);
            3'd3:    lit = (seg_e & left) | (seg_c & right);
            3'd4:    lit = seg_d | (seg_e & left) | (seg_c & right);
            default: lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit cell for a ripple-carry decimal counter. Values above 9
// (only reachable by load) roll to 0 with carry on the next increment.
module bcd_digit_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out
);
    import video_pkg::*;

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       wrap;

    assign wrap      = (digit_q >= 4'd9);
    assign carry_out = carry_in & ~load & wrap;
    assign digit     = digit_q;

    // Next digit value: load has priority over increment.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (carry_in) begin
            digit_d = wrap ? 4'd0 : digit_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/seven_segment_overlay.sv
// Multi-digit BCD frame counter rendered as scaled seven-segment glyphs
// over the VGA pixel stream, with a two-stage pixel pipeline.
module seven_segment_overlay #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCALE_LOG2    = 1,
    parameter int X0            = 64,
    parameter int Y0            = 32,
    parameter int BLANK_LEADING = 1,
    parameter int POS_W         = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [POS_W-1:0]        hpos,
    input  logic [POS_W-1:0]        vpos,
    input  logic                    video_active,
    input  logic                    vsync,
    input  logic                    inc_en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    pixel_on,
    output logic                    pixel_valid,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    carry_out
);
    import video_pkg::*;

    localparam logic [POS_W-1:0] X0_P     = POS_W'(X0);
    localparam logic [POS_W-1:0] Y0_P     = POS_W'(Y0);
    localparam logic [POS_W-1:0] NDIG_P   = POS_W'(NUM_DIGITS);
    localparam logic [POS_W-1:0] GLYPH_HP = POS_W'(GLYPH_H);
    localparam logic [2:0]       GLYPH_WP = 3'(GLYPH_W);

    // ---------------- frame event and counter ----------------
    logic                    prev_vsync_q;
    logic                    tick_d1_q;
    logic                    carry_q;
    logic [4*NUM_DIGITS-1:0] disp_q;
    logic                    frame_tick;
    logic [NUM_DIGITS:0]     chain;

    assign frame_tick = prev_vsync_q & ~vsync;
    // Load wins over a coincident frame tick: no increment, no carry.
    assign chain[0]   = frame_tick & inc_en & ~load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] digit_w;
            bcd_digit_counter u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (load),
                .load_digit (load_value[4*gi +: 4]),
                .carry_in   (chain[gi]),
                .digit      (digit_w),
                .carry_out  (chain[gi+1])
            );
            assign count_bcd[4*gi +: 4] = digit_w;
        end
    endgenerate

    assign carry_out = carry_q;

    // Vsync edge detect, carry pulse and tear-free display latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_vsync_q <= 1'b1;
            tick_d1_q    <= 1'b0;
            carry_q      <= 1'b0;
            disp_q       <= '0;
        end else begin
            prev_vsync_q <= vsync;
            tick_d1_q    <= frame_tick;
            carry_q      <= chain[NUM_DIGITS];
            if (tick_d1_q) begin
                disp_q <= count_bcd;
            end
        end
    end

    // ---------------- stage 1: geometry ----------------
    logic [POS_W-1:0] dx, dy, unit_x, cell_idx, row_full;
    logic             in_box_d;
    logic [2:0]       digit_idx_d, col_d, row_d;
    logic             in_box_q, va_d1_q;
    logic [2:0]       digit_idx_q, col_q, row_q;

    // Position within the glyph strip; the range guards stop a wrapped
    // subtraction from landing inside the box.
    always_comb begin
        dx          = hpos - X0_P;
        dy          = vpos - Y0_P;
        unit_x      = dx >> SCALE_LOG2;
        cell_idx    = unit_x >> 3;
        row_full    = dy >> SCALE_LOG2;
        col_d       = unit_x[2:0];
        row_d       = row_full[2:0];
        digit_idx_d = cell_idx[2:0];
        in_box_d    = (hpos >= X0_P) && (vpos >= Y0_P) &&
                      (cell_idx < NDIG_P) && (col_d < GLYPH_WP) &&
                      (row_full < GLYPH_HP);
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_q    <= 1'b0;
            digit_idx_q <= 3'd0;
            col_q       <= 3'd0;
            row_q       <= 3'd0;
            va_d1_q     <= 1'b0;
        end else begin
            in_box_q    <= in_box_d;
            digit_idx_q <= digit_idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            va_d1_q     <= video_active;
        end
    end

    // ---------------- stage 2: glyph lookup ----------------
    // Screen digit 0 is the most significant nibble of the display latch.
    logic [3:0]            screen_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_run;
    logic [NUM_DIGITS-1:0] blank;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_screen
            assign screen_digit[gi] = disp_q[4*(NUM_DIGITS-1-gi) +: 4];
            if (gi == 0) begin : g_first
                assign zero_run[gi] = (screen_digit[gi] == 4'd0);
            end else begin : g_rest
                assign zero_run[gi] = zero_run[gi-1] & (screen_digit[gi] == 4'd0);
            end
            assign blank[gi] = (BLANK_LEADING != 0) && (gi != NUM_DIGITS - 1) && zero_run[gi];
        end
    endgenerate

    logic [3:0] sel_digit;
    logic       sel_blank;
    logic [6:0] sel_seg;
    logic       glyph_on;
    logic       pixel_on_q, pixel_valid_q;

    // Pick the digit under the beam and look up its glyph unit.
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == 3'(i)) begin
                sel_digit = screen_digit[i];
                sel_blank = blank[i];
            end
        end
        sel_seg  = sel_blank ? SEG_BLANK : seg_decode(sel_digit);
        glyph_on = glyph_bit(sel_seg, col_q, row_q);
    end

    // Stage 2 output registers; pixel_on is qualified by the delayed active flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_on_q    <= in_box_q & va_d1_q & glyph_on;
            pixel_valid_q <= va_d1_q;
        end
    end

    assign pixel_on    = pixel_on_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_seven_segment_overlay.sv
// Directed bench for seven_segment_overlay: counter, carry, load priority,
// display latch timing and glyph rendering with and without blanking.
module tb_seven_segment_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hpos, vpos;
    logic        video_active, vsync, inc_en, load;
    logic [15:0] load_value;

    logic        pix_a, pv_a, co_a;
    logic [15:0] cnt_a;
    logic        pix_b, pv_b, co_b;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_segment_overlay dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .video_active(video_active), .vsync(vsync), .inc_en(inc_en),
        .load(load), .load_value(load_value),
        .pixel_on(pix_a), .pixel_valid(pv_a), .count_bcd(cnt_a), .carry_out(co_a)
    );

    seven_segment_overlay #(.BLANK_LEADING(0)) dut_nb (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .video_active(video_active), .vsync(vsync), .inc_en(inc_en),
        .load(load), .load_value(load_value),
        .pixel_on(pix_b), .pixel_valid(pv_b), .count_bcd(cnt_b), .carry_out(co_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s value=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vsync falling edge; returns after the counter update edge.
    task automatic vsync_fall();
        vsync = 1'b0;
        step();
    endtask

    task automatic vsync_rise();
        vsync = 1'b1;
        step();
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        step();
        load       = 1'b0;
    endtask

    // Present a pixel and wait out the 2-cycle pipeline.
    task automatic pix(input int h, input int v, input logic va);
        hpos         = 11'(h);
        vpos         = 11'(v);
        video_active = va;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1; hpos = '0; vpos = '0; video_active = 1'b0;
        vsync = 1'b1; inc_en = 1'b0; load = 1'b0; load_value = '0;
        repeat (3) step();
        check("rst_count", 32'(cnt_a), 32'h0);
        check("rst_carry", 32'(co_a), 32'h0);
        check("rst_pix",   32'(pix_a), 32'h0);
        check("rst_valid", 32'(pv_a), 32'h0);
        reset = 1'b0;
        step();
        check("idle_count", 32'(cnt_a), 32'h0);

        // Three frames with increment enabled; latch lags the count by one cycle.
        inc_en = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            vsync_fall();
            check($sformatf("f%0d_count", f), 32'(cnt_a), 32'(f));
            check($sformatf("f%0d_disp_old", f), 32'(dut.disp_q), 32'(f - 1));
            vsync_rise();
            check($sformatf("f%0d_disp_new", f), 32'(dut.disp_q), 32'(f));
        end
        check("f3_carry", 32'(co_a), 32'h0);

        // Wrap from all 9s.
        do_load(16'h9999);
        check("ld9999_count", 32'(cnt_a), 32'h9999);
        check("ld9999_carry", 32'(co_a), 32'h0);
        vsync_fall();
        check("wrap_count", 32'(cnt_a), 32'h0);
        check("wrap_carry_hi", 32'(co_a), 32'h1);
        vsync_rise();
        check("wrap_carry_lo", 32'(co_a), 32'h0);
        check("wrap_count_hold", 32'(cnt_a), 32'h0);

        // Load coincident with a frame tick: load wins.
        load = 1'b1; load_value = 16'h0042; vsync = 1'b0;
        step();
        load = 1'b0;
        check("ldtick_count", 32'(cnt_a), 32'h0042);
        check("ldtick_carry", 32'(co_a), 32'h0);
        vsync_rise();
        check("ldtick_hold", 32'(cnt_a), 32'h0042);
        check("ldtick_disp", 32'(dut.disp_q), 32'h0042);

        // Non-decimal digit rolls to 0 with carry into the next digit.
        do_load(16'h000C);
        vsync_fall();
        check("hexdig_count", 32'(cnt_a), 32'h0010);
        vsync_rise();

        // Display 0x0008: digit 3 spans columns 112..121, rows 32..41.
        inc_en = 1'b0;
        do_load(16'h0008);
        vsync_fall();
        vsync_rise();
        check("d8_disp", 32'(dut.disp_q), 32'h0008);
        pix(112, 32, 1'b1); check("d8_r0_left",  32'(pix_a), 32'h1);
        check("d8_valid", 32'(pv_a), 32'h1);
        pix(121, 32, 1'b1); check("d8_r0_right", 32'(pix_a), 32'h1);
        pix(122, 32, 1'b1); check("d8_col5_off", 32'(pix_a), 32'h0);
        pix(116, 33, 1'b1); check("d8_r0_mid",   32'(pix_a), 32'h1);
        pix(116, 34, 1'b1); check("d8_r1_mid_off", 32'(pix_a), 32'h0);
        pix(112, 34, 1'b1); check("d8_r1_f",     32'(pix_a), 32'h1);
        pix(116, 36, 1'b1); check("d8_r2_g",     32'(pix_a), 32'h1);
        pix(116, 41, 1'b1); check("d8_r4_d",     32'(pix_a), 32'h1);
        pix(116, 42, 1'b1); check("d8_below_off", 32'(pix_a), 32'h0);
        pix(64, 32, 1'b1);  check("d8_dig0_blank", 32'(pix_a), 32'h0);
        check("d8_dig0_noblank", 32'(pix_b), 32'h1);
        pix(96, 32, 1'b1);  check("d8_dig2_blank", 32'(pix_a), 32'h0);
        pix(63, 32, 1'b1);  check("left_of_box", 32'(pix_b), 32'h0);
        pix(10, 32, 1'b1);  check("hpos_wrap_guard", 32'(pix_b), 32'h0);
        pix(64, 31, 1'b1);  check("above_box", 32'(pix_b), 32'h0);
        pix(112, 32, 1'b0); check("inactive_pix", 32'(pix_a), 32'h0);
        check("inactive_valid", 32'(pv_a), 32'h0);

        // Display 0x0001 without blanking: digit 0 renders "0".
        do_load(16'h0001);
        vsync_fall();
        vsync_rise();
        pix(64, 32, 1'b1);  check("d1_nb_c0", 32'(pix_b), 32'h1);
        check("d1_bl_c0", 32'(pix_a), 32'h0);
        pix(73, 32, 1'b1);  check("d1_nb_c4", 32'(pix_b), 32'h1);
        pix(74, 32, 1'b1);  check("d1_nb_c5", 32'(pix_b), 32'h0);
        pix(112, 32, 1'b1); check("d1_one_left_off", 32'(pix_a), 32'h0);
        pix(121, 32, 1'b1); check("d1_one_b", 32'(pix_a), 32'h1);

        // Reset during a lit pixel.
        pix(64, 32, 1'b1);  check("pre_rst_lit", 32'(pix_b), 32'h1);
        reset = 1'b1;
        step();
        check("midrst_pix",   32'(pix_b), 32'h0);
        check("midrst_valid", 32'(pv_b), 32'h0);
        check("midrst_count", 32'(cnt_b), 32'h0);
        reset = 1'b0;
        step();
        check("postrst_gap", 32'(pix_b), 32'h0);
        step();
        check("postrst_nb_zero", 32'(pix_b), 32'h1);
        check("postrst_bl_dig0", 32'(pix_a), 32'h0);
        pix(112, 32, 1'b1); check("postrst_bl_dig3", 32'(pix_a), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
